// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - counter/mode inputs and pixel outputs of the pattern generator
interface vga_pattern_gen_if #(
  parameter int CNT_W = 12,
  parameter int R_W   = 3,
  parameter int G_W   = 3,
  parameter int B_W   = 2
);
  logic [CNT_W-1:0]         line_cnt;
  logic [CNT_W-1:0]         ver_cnt;
  logic [1:0]               mode_i;
  logic                     mode_we;
  logic [R_W+G_W+B_W-1:0]   rgb_o;
  logic                     de_o;
  logic                     frame_start_o;

  modport master (
    output line_cnt, ver_cnt, mode_i, mode_we,
    input  rgb_o, de_o, frame_start_o
  );

  modport slave (
    input  line_cnt, ver_cnt, mode_i, mode_we,
    output rgb_o, de_o, frame_start_o
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test pattern generator (box, bars, checker, bouncing box)
module vga_pattern_gen #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1,
  parameter int CNT_W    = 12,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int BOX_X0   = 200,
  parameter int BOX_Y0   = 200,
  parameter int BOX_SIZE = 200,
  parameter int STEP     = 2,
  parameter int CHK_SH   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_pattern_gen_if.slave bus
);
  localparam int W  = CNT_W + 1;
  localparam int PW = R_W + G_W + B_W;

  localparam logic [W-1:0] HSTART = W'(H_SYNC + H_BACK);
  localparam logic [W-1:0] HEND   = W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [W-1:0] VSTART = W'(V_SYNC + V_BACK);
  localparam logic [W-1:0] VEND   = W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [W-1:0] SX0    = W'(BOX_X0);
  localparam logic [W-1:0] SX1    = W'(BOX_X0 + BOX_SIZE);
  localparam logic [W-1:0] SY0    = W'(BOX_Y0);
  localparam logic [W-1:0] SY1    = W'(BOX_Y0 + BOX_SIZE);
  localparam logic [W-1:0] SIZE_W = W'(BOX_SIZE);
  localparam logic [W-1:0] STEP_W = W'(STEP);
  localparam logic [W-1:0] HACT_W = W'(H_ACTIVE);
  localparam logic [W-1:0] VACT_W = W'(V_ACTIVE);

  localparam logic [PW-1:0] RED   = {{R_W{1'b1}}, {(G_W + B_W){1'b0}}};
  localparam logic [PW-1:0] GREEN = {{R_W{1'b0}}, {G_W{1'b1}}, {B_W{1'b0}}};
  localparam logic [PW-1:0] BLUE  = {{(R_W + G_W){1'b0}}, {B_W{1'b1}}};
  localparam logic [PW-1:0] WHITE = {PW{1'b1}};

  logic [1:0]       pending_mode, active_mode, new_mode;
  logic [CNT_W-1:0] box_x, box_y;
  logic             dir_x, dir_y;
  logic [PW-1:0]    rgb_q;
  logic             de_q, fs_q;

  logic [W-1:0]  lc, vc, x, y, bx, by;
  logic          active, frame_start, in_sbox, in_bbox;
  logic [2:0]    bar, bar_bits;
  logic [PW-1:0] pix;
  logic [W-1:0]  step_x, step_y;

  // All arithmetic is one bit wider than the counters so box sums never wrap.
  assign lc = {1'b0, bus.line_cnt};
  assign vc = {1'b0, bus.ver_cnt};
  assign x  = lc - HSTART;
  assign y  = vc - VSTART;
  assign bx = {1'b0, box_x};
  assign by = {1'b0, box_y};

  assign active      = (lc >= HSTART) && (lc < HEND) && (vc >= VSTART) && (vc < VEND);
  assign frame_start = (bus.line_cnt == '0) && (bus.ver_cnt == '0);
  assign new_mode    = bus.mode_we ? bus.mode_i : pending_mode;

  assign in_sbox = (x >= SX0) && (x <= SX1) && (y >= SY0) && (y <= SY1);
  assign in_bbox = (x >= bx) && (x < bx + SIZE_W) && (y >= by) && (y < by + SIZE_W);

  // Returns {new_dir, new_pos}; clamps to the far edge and reverses on overshoot.
  function automatic logic [W-1:0] axis_step(input logic [W-1:0] pos, input logic dir,
                                             input logic [W-1:0] limit);
    if (!dir) begin
      if (pos + STEP_W + SIZE_W > limit)
        return {1'b1, CNT_W'(limit - SIZE_W)};
      else
        return {1'b0, CNT_W'(pos + STEP_W)};
    end else begin
      if (pos < STEP_W)
        return {1'b0, {CNT_W{1'b0}}};
      else
        return {1'b1, CNT_W'(pos - STEP_W)};
    end
  endfunction

  assign step_x = axis_step(bx, dir_x, HACT_W);
  assign step_y = axis_step(by, dir_y, VACT_W);

  always_comb begin
    pix      = '0;
    bar      = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (x >= W'(k * (H_ACTIVE / 8)))
        bar = 3'(k);
    end
    bar_bits = 3'd7 - bar;
    case (active_mode)
      2'd0:    pix = in_sbox ? RED : GREEN;
      2'd1:    pix = ({PW{bar_bits[2]}} & RED) | ({PW{bar_bits[1]}} & GREEN)
                   | ({PW{bar_bits[0]}} & BLUE);
      2'd2:    pix = (x[CHK_SH] ^ y[CHK_SH]) ? '0 : WHITE;
      default: pix = in_bbox ? BLUE : '0;
    endcase
    if (!active)
      pix = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q        <= '0;
      de_q         <= 1'b0;
      fs_q         <= 1'b0;
      pending_mode <= 2'd0;
      active_mode  <= 2'd0;
      box_x        <= '0;
      box_y        <= '0;
      dir_x        <= 1'b0;
      dir_y        <= 1'b0;
    end else begin
      rgb_q <= pix;
      de_q  <= active;
      fs_q  <= frame_start;
      if (bus.mode_we)
        pending_mode <= bus.mode_i;
      if (frame_start) begin
        active_mode <= new_mode;
        if (new_mode == 2'd3) begin
          {dir_x, box_x} <= step_x;
          {dir_y, box_y} <= step_y;
        end
      end
    end
  end

  assign bus.rgb_o         = rgb_q;
  assign bus.de_o          = de_q;
  assign bus.frame_start_o = fs_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - randomized and directed bench for vga_pattern_gen
module tb_vga_pattern_gen;
  localparam int HS = 216;
  localparam int VS = 27;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_pattern_gen_if bus ();
  vga_pattern_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nchk = 0;
  int nfail = 0;
  bit chk_on = 1'b1;

  logic [7:0] e_rgb = 8'h00;
  logic       e_de  = 1'b0;
  logic       e_fs  = 1'b0;

  int pend = 0, act = 0, bx = 0, by = 0, dx = 0, dy = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [8:0] model_pix(input int lc, input int vc, input int mode,
                                           input int px, input int py);
    int x, y, bits;
    x = lc - HS;
    y = vc - VS;
    if (x < 0 || x >= 800 || y < 0 || y >= 600) return 9'h000;
    case (mode)
      0: return (x >= 200 && x <= 400 && y >= 200 && y <= 400) ? 9'h1E0 : 9'h11C;
      1: begin
        bits = 7 - x / 100;
        return {1'b1, ((bits & 4) != 0) ? 8'hE0 : 8'h00}
             | {1'b0, ((bits & 2) != 0) ? 8'h1C : 8'h00}
             | {1'b0, ((bits & 1) != 0) ? 8'h03 : 8'h00};
      end
      2: return (((x / 32) + (y / 32)) % 2 == 0) ? 9'h1FF : 9'h100;
      default: return (x >= px && x < px + 200 && y >= py && y < py + 200) ? 9'h103 : 9'h100;
    endcase
  endfunction

  function automatic void move_axis(inout int p, inout int d, input int lim);
    if (d == 0) begin
      if (p + 2 + 200 > lim) begin p = lim - 200; d = 1; end
      else p = p + 2;
    end else begin
      if (p < 2) begin p = 0; d = 0; end
      else p = p - 2;
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("rgb", {24'd0, bus.rgb_o}, {24'd0, e_rgb});
      chk("de", {31'd0, bus.de_o}, {31'd0, e_de});
      chk("frame_start", {31'd0, bus.frame_start_o}, {31'd0, e_fs});
    end
  end

  task automatic drive(input int lc, input int vc, input int m, input bit we);
    logic [8:0] p;
    @(negedge clk);
    bus.line_cnt = 12'(lc);
    bus.ver_cnt  = 12'(vc);
    bus.mode_i   = 2'(m);
    bus.mode_we  = we;
    p = model_pix(lc, vc, act, bx, by);
    e_de  = p[8];
    e_rgb = p[7:0];
    e_fs  = (lc == 0 && vc == 0);
    if (we) pend = m;
    if (lc == 0 && vc == 0) begin
      act = pend;
      if (act == 3) begin
        move_axis(bx, dx, 800);
        move_axis(by, dy, 600);
      end
    end
  endtask

  task automatic probe(input string nm, input int lc, input int vc,
                       input logic [7:0] lit_rgb, input logic lit_de);
    drive(lc, vc, 0, 1'b0);
    @(posedge clk);
    #2;
    chk({nm, "_rgb"}, {24'd0, bus.rgb_o}, {24'd0, lit_rgb});
    chk({nm, "_de"}, {31'd0, bus.de_o}, {31'd0, lit_de});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.line_cnt = 12'd5;
    bus.ver_cnt  = 12'd5;
    bus.mode_i   = 2'd0;
    bus.mode_we  = 1'b0;
    e_rgb = 8'h00; e_de = 1'b0; e_fs = 1'b0;
    pend = 0; act = 0; bx = 0; by = 0; dx = 0; dy = 0;
    #1;
    chk("rst_rgb", {24'd0, bus.rgb_o}, 32'd0);
    chk("rst_de", {31'd0, bus.de_o}, 32'd0);
    chk("rst_fs", {31'd0, bus.frame_start_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lc, vc;
    bus.line_cnt = 12'd5;
    bus.ver_cnt  = 12'd5;
    bus.mode_i   = 2'd0;
    bus.mode_we  = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_rgb", {24'd0, bus.rgb_o}, 32'd0);
    chk("init_de", {31'd0, bus.de_o}, 32'd0);
    rst_n = 1'b1;

    probe("m0_corner", 416, 227, 8'hE0, 1'b1);
    probe("m0_left", 415, 227, 8'h1C, 1'b1);
    probe("m0_blank", 100, 100, 8'h00, 1'b0);
    probe("m0_edge", 616, 427, 8'hE0, 1'b1);

    drive(500, 300, 2, 1'b1);
    probe("pend_hold", 416, 227, 8'hE0, 1'b1);
    drive(0, 0, 0, 1'b0);
    @(posedge clk); #2;
    chk("fs_pulse", {31'd0, bus.frame_start_o}, 32'd1);
    probe("m2_white", HS, VS, 8'hFF, 1'b1);
    chk("fs_single", {31'd0, bus.frame_start_o}, 32'd0);
    probe("m2_black", HS + 32, VS, 8'h00, 1'b1);

    drive(0, 0, 1, 1'b1);
    probe("m1_x0", HS, VS, 8'hFF, 1'b1);
    probe("m1_x100", HS + 100, VS, 8'hFC, 1'b1);
    probe("m1_x799", HS + 799, VS, 8'h00, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        lc = 0; vc = 0;
      end else if ($urandom_range(0, 3) != 0) begin
        lc = HS + $urandom_range(0, 799); vc = VS + $urandom_range(0, 599);
      end else begin
        lc = $urandom_range(0, 1055); vc = $urandom_range(0, 627);
      end
      drive(lc, vc, $urandom_range(0, 3), $urandom_range(0, 19) == 0);
    end

    do_reset();
    drive(10, 10, 3, 1'b1);
    for (int k = 1; k <= 302; k++) begin
      drive(0, 0, 0, 1'b0);
      drive(HS + bx - 1, VS + by, 0, 1'b0);
      drive(HS + bx, VS + by, 0, 1'b0);
      drive(HS + bx + 199, VS + by + 199, 0, 1'b0);
      drive(HS + bx + 200, VS + by, 0, 1'b0);
      drive(HS + bx, VS + by - 1, 0, 1'b0);
      drive(HS + bx, VS + by + 200, 0, 1'b0);
      for (int j = 0; j < 3; j++)
        drive(HS + $urandom_range(0, 799), VS + $urandom_range(0, 599), 0, 1'b0);
      if (k == 200) chk("model_by200", by, 400);
      if (k == 300) begin
        chk("model_bx300", bx, 600);
        probe("b300_in", HS + 600, 229, 8'h03, 1'b1);
        probe("b300_out", HS + 599, 229, 8'h00, 1'b1);
      end
      if (k == 301) chk("model_dx301", dx, 1);
      if (k == 302) begin
        chk("model_bx302", bx, 598);
        probe("b302_in", HS + 598, VS + 198, 8'h03, 1'b1);
        probe("b302_out", HS + 597, VS + 198, 8'h00, 1'b1);
      end
    end

    drive(HS + bx + 5, VS + by + 5, 0, 1'b0);
    do_reset();
    probe("post_rst_m0", 416, 227, 8'hE0, 1'b1);
    drive(10, 10, 3, 1'b1);
    drive(0, 0, 0, 1'b0);
    probe("post_rst_box_in", HS + 2, VS + 2, 8'h03, 1'b1);
    probe("post_rst_box_out", HS + 1, VS + 2, 8'h00, 1'b1);
    probe("post_rst_box_top", HS + 2, VS + 1, 8'h00, 1'b1);

    @(posedge clk); #2;
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule
